// File: rtl/muldiv_controller_if.sv
// Issue/result bundle between the execute/decode stages and the multiply-divide unit.
// The master side issues operations; the slave side (the unit) returns HI/LO and status.
interface muldiv_controller_if;
   logic        e_start_mul;
   logic        e_start_div;
   logic        e_signed;
   logic [31:0] e_a;
   logic [31:0] e_b;
   logic        d_hilo_read;
   logic        d_md_op;
   logic        md_abort;
   logic        busy;
   logic        md_stall;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output e_start_mul, e_start_div, e_signed, e_a, e_b, d_hilo_read, d_md_op, md_abort,
      input  busy, md_stall, done, div_by_zero, hi, lo
   );

   modport slave (
      input  e_start_mul, e_start_div, e_signed, e_a, e_b, d_hilo_read, d_md_op, md_abort,
      output busy, md_stall, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_controller.sv
// Iterative 32x32 multiply / 32/32 divide unit owning HI/LO: 34 edges from issue to result.
// Optional MULDIV_ABORT_EN lets md_abort cancel an in-flight operation.
module muldiv_controller (
   input  logic               clk,
   input  logic               reset,
   muldiv_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

   state_t      state, state_nx;
   logic [4:0]  cnt;
   logic [63:0] acc;      // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}
   logic [31:0] opb;
   logic        op_div;
   logic        neg_q;
   logic        neg_r;
   logic        b_zero;
   logic        abort;
   logic        start;

   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum, div_trial;
   logic [63:0] acc_step, prod_fix;
   logic [31:0] q_fix, r_fix;

`ifdef MULDIV_ABORT_EN
   assign abort = bus.md_abort && (state != IDLE);
`else
   assign abort = 1'b0;
`endif

   assign start        = bus.e_start_mul || bus.e_start_div;
   assign bus.busy     = (state != IDLE);
   assign bus.md_stall = bus.busy & (bus.d_hilo_read | bus.d_md_op);

   always_comb begin
      a_mag = bus.e_a;
      b_mag = bus.e_b;
      if (bus.e_signed && bus.e_a[31]) a_mag = ~bus.e_a + 32'd1;
      if (bus.e_signed && bus.e_b[31]) b_mag = ~bus.e_b + 32'd1;
   end

   // One shift-add or one restoring-division step per edge.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opb : 32'd0)};
      div_trial = {acc[63:32], acc[31]} - {1'b0, opb};
      acc_step  = acc;
      if (state == MUL)
         acc_step = {mul_sum, acc[31:1]};
      else if (div_trial[32])
         acc_step = {acc[62:0], 1'b0};
      else
         acc_step = {div_trial[31:0], acc[30:0], 1'b1};
   end

   // Division by zero falls out as remainder = |a|, so the remainder sign fixup restores a.
   always_comb begin
      prod_fix = neg_q ? (~acc + 64'd1) : acc;
      q_fix    = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
      r_fix    = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
      if (b_zero) q_fix = 32'hFFFF_FFFF;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (bus.e_start_mul)      state_nx = MUL;
            else if (bus.e_start_div) state_nx = DIV;
         end
         MUL, DIV: if (cnt == 5'd31) state_nx = FIXUP;
         FIXUP:    state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt             <= '0;
         acc             <= '0;
         opb             <= '0;
         op_div          <= 1'b0;
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
         b_zero          <= 1'b0;
         bus.hi          <= '0;
         bus.lo          <= '0;
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               op_div <= !bus.e_start_mul;
               acc    <= {32'd0, a_mag};
               opb    <= b_mag;
               cnt    <= '0;
               neg_q  <= bus.e_signed && (bus.e_a[31] ^ bus.e_b[31]);
               neg_r  <= bus.e_signed && bus.e_a[31];
               b_zero <= (bus.e_b == 32'd0);
            end
         end else if (!abort) begin
            if (state == FIXUP) begin
               bus.done <= 1'b1;
               if (op_div) begin
                  bus.hi          <= r_fix;
                  bus.lo          <= q_fix;
                  bus.div_by_zero <= b_zero;
               end else begin
                  bus.hi <= prod_fix[63:32];
                  bus.lo <= prod_fix[31:0];
               end
            end else begin
               acc <= acc_step;
               cnt <= cnt + 5'd1;
            end
         end
      end
   end
endmodule

// File: doc/muldiv_controller.md
MULDIV_CONTROLLER -- requirements
Module: muldiv_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 e_start_mul  input  1  execute-stage MULT/MULTU issue.
REQ-005 e_start_div  input  1  execute-stage DIV/DIVU issue.
REQ-006 e_signed  input  1  1 = signed operation, 0 = unsigned.
REQ-007 e_a, e_b  input  32  rs/rt operands, sampled only at start.
REQ-008 d_hilo_read  input  1  decode-stage MFHI/MFLO.
REQ-009 d_md_op  input  1  decode-stage mul/div/MTHI/MTLO.
REQ-010 md_abort  input  1  cancel in-flight operation; used only under MULDIV_ABORT_EN.
REQ-011 busy  output  1  operation in flight.
REQ-012 md_stall  output  1  stall request, ORed into f_stall/d_stall by the hazard controller.
REQ-013 hi, lo  output  32  architectural HI/LO registers.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 div_by_zero  output  1  sticky flag for the last DIV with b==0.

Function
REQ-016 States SHALL be IDLE, MUL, DIV and FIXUP, plus a 5-bit iteration counter.
REQ-017 IDLE SHALL sample starts: e_start_mul -> MUL, else e_start_div -> DIV; both asserted -> MUL wins; the sampling edge is edge 0.
REQ-018 At edge 0 the block SHALL latch operand magnitudes (absolute value if e_signed), result signs, and counter = 0.
REQ-019 Starts while not IDLE SHALL be ignored; no queueing.
REQ-020 MUL SHALL perform one shift-add step per edge over edges 1..32, with a 64-bit accumulator.
REQ-021 DIV SHALL perform one restoring-division step per edge over edges 1..32, building the quotient and remainder.
REQ-022 At edge 32 (counter == 31) the block SHALL enter FIXUP.
REQ-023 At edge 33 FIXUP SHALL apply sign correction, write hi/lo, pulse done for one cycle, and return to IDLE.
REQ-024 Result visibility: hi/lo updated after edge 33; busy = (state != IDLE), high from edge 0 to edge 33.
REQ-025 MUL result: {hi,lo} = 64-bit product, two's complement when signed.
REQ-026 DIV result: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-027 DIV with b == 0 SHALL give lo = 32'hFFFFFFFF, hi = a, div_by_zero = 1, with the same latency.
REQ-028 Any other completed DIV SHALL clear div_by_zero; MUL SHALL leave it unchanged.
REQ-029 md_stall SHALL be combinational: busy & (d_hilo_read | d_md_op).
REQ-030 md_stall SHALL fall in the cycle hi/lo become valid, so a held MFHI reads the new value.
REQ-031 Signed boundary: 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0.
REQ-032 Signed boundary: 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
REQ-033 The block SHALL not alter hi/lo except in FIXUP.

Reset
REQ-034 Asserting reset (low) SHALL immediately force state IDLE, counter 0, hi = lo = 0, done = 0, div_by_zero = 0, busy = 0, md_stall = 0.
REQ-035 Reset mid-operation SHALL discard the operation with no done pulse; the first start after deassertion is accepted normally.

Configuration
REQ-036 Macro MULDIV_ABORT_EN, when defined, SHALL make md_abort high in any non-IDLE state force IDLE at the next edge, with hi/lo/div_by_zero unchanged and no done pulse.
REQ-037 Abort SHALL take priority over FIXUP completion; a start coincident with abort in IDLE is accepted.
REQ-038 Without MULDIV_ABORT_EN, md_abort SHALL remain a port but be ignored, and operations always complete.

Verification
REQ-039 Unsigned mul 0xFFFFFFFF * 2 -> after edge 33: hi = 1, lo = 0xFFFFFFFE; done high exactly one cycle; busy high edges 0..33.
REQ-040 Signed div -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-041 Unsigned div 5 / 0 -> lo = 0xFFFFFFFF, hi = 5, div_by_zero = 1; a following 9 / 3 clears it (lo = 3, hi = 0).
REQ-042 d_hilo_read held from edge 10 -> md_stall = 1 until edge 33, 0 after; e_start_div at edge 5 is ignored.
REQ-043 Reset pulsed low at edge 15 of a mul -> outputs zero immediately; no done; new mul 3 * 4 yields lo = 12.
REQ-044 With MULDIV_ABORT_EN, md_abort at edge 5 -> busy 0 after edge 6, hi/lo keep prior values; without the macro -> completes at edge 33.
